// File: rtl/bcd_digit_collector_pkg.sv
// Shared constants and types for the BCD digit collector and its serializer.
package bcd_digit_collector_pkg;

    localparam int DIGITS_DEFAULT = 11;

    localparam logic [3:0] CODE_BKSP = 4'hA;
    localparam logic [3:0] CODE_CLR  = 4'hB;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_digit_collector.sv
// Collects keyed BCD digits into a packed word with a valid/ready handoff.
// Optional editing codes (backspace/clear) are enabled by BCD_COLLECTOR_EDIT_EN.
module bcd_digit_collector
    import bcd_digit_collector_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [3:0]                    in_code,
    output logic                          in_ready,
    output logic [4*DIGITS-1:0]           num_out,
    output logic                          num_valid,
    input  logic                          num_ready,
    output logic [$clog2(DIGITS+1)-1:0]   digit_cnt,
    output logic                          err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    state_t          r_state;
    logic [W-1:0]    r_num;
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    state_t          w_state_nxt;
    logic [W-1:0]    w_num_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_err_nxt;
    logic            w_accept;

    assign in_ready  = (r_state == COLLECT);
    assign num_valid = (r_state == HOLD);
    assign num_out   = r_num;
    assign digit_cnt = r_cnt;
    assign err       = r_err;
    assign w_accept  = in_valid && (r_state == COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
            r_num   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_num   <= w_num_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_num_nxt   = r_num;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;

        case (r_state)
            COLLECT: begin
                if (w_accept) begin
                    if (in_code <= 4'd9) begin
                        for (int unsigned k = 0; k < DIGITS; k++) begin
                            if (CW'(k) == r_cnt) w_num_nxt[4*k +: 4] = in_code;
                        end
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (r_cnt == CW'(DIGITS - 1)) w_state_nxt = HOLD;
                    end
`ifdef BCD_COLLECTOR_EDIT_EN
                    else if (in_code == CODE_BKSP) begin
                        // Backspace at an empty word is silently ignored.
                        if (r_cnt != '0) begin
                            for (int unsigned k = 0; k < DIGITS; k++) begin
                                if (CW'(k + 1) == r_cnt) w_num_nxt[4*k +: 4] = 4'h0;
                            end
                            w_cnt_nxt = r_cnt - 1'b1;
                        end
                    end else if (in_code == CODE_CLR) begin
                        w_num_nxt = '0;
                        w_cnt_nxt = '0;
                    end
`endif
                    else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (num_ready) begin
                    w_num_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

endmodule

// File: tb/tb_bcd_digit_collector.sv
// Randomized self-checking bench for bcd_digit_collector against a queue-based model.
// Honours BCD_COLLECTOR_EDIT_EN the same way the design does.
module tb_bcd_digit_collector;
    import bcd_digit_collector_pkg::*;

    localparam int D  = DIGITS_DEFAULT;
    localparam int W  = 4 * D;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [3:0]    in_code = 4'h0;
    logic          in_ready;
    logic [W-1:0]  num_out;
    logic          num_valid;
    logic          num_ready = 1'b0;
    logic [CW-1:0] digit_cnt;
    logic          err;

    bcd_digit_collector #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .in_ready  (in_ready),
        .num_out   (num_out),
        .num_valid (num_valid),
        .num_ready (num_ready),
        .digit_cnt (digit_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   q[$];
    logic m_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_word();
        logic [W-1:0] w = '0;
        foreach (q[k]) w = w | (W'(q[k]) << (4 * k));
        return w;
    endfunction

    task automatic check_all();
        check("num_out",   64'(num_out),   64'(model_word()));
        check("digit_cnt", 64'(digit_cnt), 64'(q.size()));
        check("num_valid", 64'(num_valid), 64'(q.size() == D));
        check("in_ready",  64'(in_ready),  64'(q.size() != D));
        check("err",       64'(err),       64'(m_err));
    endtask

    // Drive one cycle of inputs, advance the model by the rules, compare after the edge.
    task automatic step(input logic v, input logic [3:0] c, input logic r);
        in_valid  = v;
        in_code   = c;
        num_ready = r;
        @(posedge clk);
        m_err = 1'b0;
        if (q.size() == D) begin
            if (r) q.delete();
        end else if (v) begin
            if (c <= 4'd9) q.push_back(int'(c));
`ifdef BCD_COLLECTOR_EDIT_EN
            else if (c == CODE_BKSP) begin
                if (q.size() > 0) void'(q.pop_back());
            end else if (c == CODE_CLR) q.delete();
`endif
            else m_err = 1'b1;
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        num_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_err = 1'b0;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_all();
    endtask

    task automatic enter(input int n, input logic [3:0] vals [16]);
        for (int i = 0; i < n; i++) step(1'b1, vals[i], 1'b0);
    endtask

    logic [3:0] seq [16];

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_all();

        // Full word in entry order.
        seq = '{4'd1, 4'd3, 4'd8, 4'd0, 4'd0, 4'd1, 4'd3, 4'd8, 4'd0, 4'd0, 4'd0,
                4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        enter(D, seq);
        check("full_word", 64'(num_out), 64'h000_8310_0831);
        check("full_valid", 64'(num_valid), 64'd1);
        check("full_ready", 64'(in_ready), 64'd0);

        // HOLD ignores input until handshake.
        repeat (4) step(1'b1, 4'd5, 1'b0);
        check("hold_word", 64'(num_out), 64'h000_8310_0831);
        check("hold_cnt", 64'(digit_cnt), 64'(D));
        step(1'b0, 4'd0, 1'b1);
        check("hs_valid", 64'(num_valid), 64'd0);
        check("hs_word", 64'(num_out), 64'd0);
        check("hs_ready", 64'(in_ready), 64'd1);

        // Backspace editing.
        step(1'b1, 4'd7, 1'b1);
        step(1'b1, 4'd2, 1'b1);
        step(1'b1, CODE_BKSP, 1'b1);
        step(1'b1, 4'd4, 1'b0);
`ifdef BCD_COLLECTOR_EDIT_EN
        check("bksp_word", 64'(num_out), 64'h47);
        check("bksp_cnt", 64'(digit_cnt), 64'd2);
`else
        check("bksp_word", 64'(num_out), 64'h427);
`endif
        do_reset();
        step(1'b1, CODE_BKSP, 1'b0);
`ifdef BCD_COLLECTOR_EDIT_EN
        check("bksp_zero_err", 64'(err), 64'd0);
`else
        check("bksp_zero_err", 64'(err), 64'd1);
`endif
        step(1'b0, 4'd0, 1'b0);

        // Clear editing.
        do_reset();
        seq = '{4'd9, 4'd9, 4'd9, CODE_CLR, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        enter(4, seq);
`ifdef BCD_COLLECTOR_EDIT_EN
        check("clr_word", 64'(num_out), 64'd0);
        check("clr_err", 64'(err), 64'd0);
`else
        check("clr_word", 64'(num_out), 64'h999);
        check("clr_err", 64'(err), 64'd1);
`endif
        step(1'b0, 4'd0, 1'b0);
        check("clr_err_gone", 64'(err), 64'd0);

        // Illegal code at cnt=3.
        do_reset();
        seq = '{4'd1, 4'd2, 4'd3, 4'hE, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
                4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        enter(4, seq);
        check("ill_err", 64'(err), 64'd1);
        check("ill_word", 64'(num_out), 64'h321);
        check("ill_cnt", 64'(digit_cnt), 64'd3);
        step(1'b0, 4'd0, 1'b0);
        check("ill_err_once", 64'(err), 64'd0);

        // Reset mid-word, then a fresh word.
        for (int i = 0; i < 6; i++) step(1'b1, 4'($urandom_range(0, 9)), 1'b0);
        do_reset();
        check("rst_word", 64'(num_out), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < D; i++) step(1'b1, 4'($urandom_range(0, 9)), 1'b0);
        check("fresh_valid", 64'(num_valid), 64'd1);
        step(1'b0, 4'd0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            logic       v;
            logic [3:0] c;
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 9))
                                           : 4'($urandom_range(10, 15));
            step(v, c, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 599) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
